// File: rtl/sample_mul_acc_pipe_if.sv
// Sample stream bundle for the pipelined multiply-accumulate block.
// The master side produces samples and the clock enable. The slave side
// returns the registered results.
interface sample_mul_acc_pipe_if #(
    parameter int A_WIDTH = 6,
    parameter int B_WIDTH = 11,
    parameter int P_WIDTH = 11
);
    logic                      ce;
    logic                      in_valid;
    logic [A_WIDTH-1:0]        din0;
    logic signed [B_WIDTH-1:0] din1;
    logic                      acc_en;
    logic                      out_valid;
    logic signed [P_WIDTH-1:0] dout;
    logic                      ovf;

    modport master (
        output ce, in_valid, din0, din1, acc_en,
        input  out_valid, dout, ovf
    );

    modport slave (
        input  ce, in_valid, din0, din1, acc_en,
        output out_valid, dout, ovf
    );
endinterface

// File: rtl/sample_mul_acc_pipe.sv
// Pipelined unsigned x signed multiply-accumulate with optional saturation.
// Stage 1 registers the sample. Stage 2 forms the full-precision product,
// and stages 3..NUM_STAGE-1 delay it. Stage NUM_STAGE adds the product to
// the running sum, detects overflow and registers the result.
module sample_mul_acc_pipe #(
    parameter int A_WIDTH   = 6,
    parameter int B_WIDTH   = 11,
    parameter int P_WIDTH   = 11,
    parameter int NUM_STAGE = 3,
    parameter int SAT_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    sample_mul_acc_pipe_if.slave  bus
);
    localparam int M_WIDTH = A_WIDTH + B_WIDTH + 1;   // full product width
    localparam int S_WIDTH = M_WIDTH + 1;             // sum width
    localparam int PD      = NUM_STAGE - 2;           // product register depth

    localparam logic signed [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

    // Stage 1 registers
    logic                      s1_valid_q;
    logic                      s1_acc_en_q;
    logic [A_WIDTH-1:0]        s1_a_q;
    logic signed [B_WIDTH-1:0] s1_b_q;

    // Product pipeline, with valid and acc_en travelling alongside
    logic signed [M_WIDTH-1:0] prod_q [PD];
    logic                      pv_q   [PD];
    logic                      pe_q   [PD];

    // Final stage. acc_q is the running sum and also the value driven on dout.
    logic                      out_valid_q;
    logic                      ovf_q;
    logic signed [P_WIDTH-1:0] acc_q;

    // Combinational product and sum
    logic signed [M_WIDTH-1:0] a_ext;
    logic signed [M_WIDTH-1:0] b_ext;
    logic signed [M_WIDTH-1:0] prod_d;
    logic signed [S_WIDTH-1:0] acc_ext;
    logic signed [S_WIDTH-1:0] prod_ext;
    logic signed [S_WIDTH-1:0] sum_d;
    logic [S_WIDTH-P_WIDTH:0]  top_bits;
    logic                      ovf_d;
    logic signed [P_WIDTH-1:0] dout_d;

    // Operands are widened to the product width first, so the multiply
    // runs at full precision with no hidden truncation.
    assign a_ext  = $signed({{(M_WIDTH-A_WIDTH){1'b0}}, s1_a_q});
    assign b_ext  = $signed({{(M_WIDTH-B_WIDTH){s1_b_q[B_WIDTH-1]}}, s1_b_q});
    assign prod_d = a_ext * b_ext;

    // Capture the incoming sample
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_acc_en_q <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
        end else if (bus.ce) begin
            s1_valid_q  <= bus.in_valid;
            s1_acc_en_q <= bus.acc_en;
            s1_a_q      <= bus.din0;
            s1_b_q      <= bus.din1;
        end
    end

    // Register the product, then shift it through the remaining delay stages
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PD; i++) begin
                prod_q[i] <= '0;
                pv_q[i]   <= 1'b0;
                pe_q[i]   <= 1'b0;
            end
        end else if (bus.ce) begin
            prod_q[0] <= prod_d;
            pv_q[0]   <= s1_valid_q;
            pe_q[0]   <= s1_acc_en_q;
            for (int i = 1; i < PD; i++) begin
                prod_q[i] <= prod_q[i-1];
                pv_q[i]   <= pv_q[i-1];
                pe_q[i]   <= pe_q[i-1];
            end
        end
    end

    // Accumulate, detect out-of-range sums and pick wrap or clamp
    always_comb begin
        acc_ext  = {{(S_WIDTH-P_WIDTH){acc_q[P_WIDTH-1]}}, acc_q};
        prod_ext = {prod_q[PD-1][M_WIDTH-1], prod_q[PD-1]};
        sum_d    = pe_q[PD-1] ? (acc_ext + prod_ext) : prod_ext;
        // The sum fits in P_WIDTH only when every bit above the result's
        // sign bit repeats that sign bit.
        top_bits = sum_d[S_WIDTH-1:P_WIDTH-1];
        ovf_d    = !((&top_bits) || !(|top_bits));
        dout_d   = sum_d[P_WIDTH-1:0];
        if ((SAT_MODE != 0) && ovf_d) begin
            dout_d = sum_d[S_WIDTH-1] ? P_MIN : P_MAX;
        end
    end

    // Register the result. A bubble only drops out_valid, so the running
    // sum survives gaps between accumulating samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else if (bus.ce) begin
            out_valid_q <= pv_q[PD-1];
            if (pv_q[PD-1]) begin
                acc_q <= dout_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = acc_q;
    assign bus.ovf       = ovf_q;
endmodule
